add_serial_arb: RTL
===================

Name: add_serial_arb

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit bit-serial adder between N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and launches the adder with a one-cycle start pulse.
- Waits for the adder's done pulse, or times out, then returns the sum tagged with the requester ID over a single valid/ready response channel.
- Sits between client blocks and the serial adder instance; it is the only driver of the adder's start and operand inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of the requester ID (clog2(N_REQ), minimum 1)
- TIMEOUT, 16, cycles in WAIT without add_done before the job is aborted with an error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_a  in  8*N_REQ  operand A, requester i in bits [8i+7:8i]
- req_b  in  8*N_REQ  operand B, same packing as req_a
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  ID_W  ID of the requester being answered
- rsp_sum  out  8  sum, modulo 256
- rsp_err  out  1  job timed out; rsp_sum is 0
- add_en  out  1  adder start, one-cycle pulse
- add_a  out  8  adder operand A
- add_b  out  8  adder operand B
- add_sum  in  8  adder result, valid while add_done is high
- add_done  in  1  adder completion, one-cycle pulse
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE; rr_ptr=0; all outputs 0 (req_ready, rsp_*, add_en, add_a, add_b, busy); timer=0.
- State encoding, 2 bits: IDLE=0, LAUNCH=1, WAIT=2, RESP=3.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after rr_ptr, searching upward with wrap.
  - In the same cycle, drive req_ready one-hot for the granted requester; this is combinational from state and req_valid.
  - On grant, register that requester's req_a/req_b into add_a/add_b, store its ID, and go to LAUNCH.
  - Update rr_ptr to (grant+1) mod N_REQ.
  - req_ready is 0 in every state other than IDLE.
- LAUNCH: add_en=1 for exactly this one cycle; clear timer; go to WAIT.
- WAIT:
  - add_a and add_b are held stable.
  - If add_done=1: capture add_sum into rsp_sum, set rsp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: set rsp_sum=0, rsp_err=1, go to RESP.
  - Else increment timer.
  - If add_done and the timeout coincide in the same cycle, add_done wins and rsp_err=0.
  - add_done arriving in any state other than WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: go to IDLE, and clear rsp_valid on the next cycle.
  - A new grant cannot happen before the cycle after the handshake.
- Latency: with the grant at cycle 0, add_en is high at cycle 1. With add_done at cycle k, rsp_valid is high at k+1. Minimum request-to-next-grant spacing is 4 cycles.
- Fairness: a continuously asserted requester is served at least once every N_REQ jobs.
- A request that drops req_valid before it is granted is simply not served.
- rst asserted mid-job: immediate return to the reset values.
  - The in-flight job is lost and no response is issued.
  - Any late add_done after reset is ignored because the FSM is in IDLE.
- busy = (state != IDLE).

Decomposition:
- Shared package add_serial_pkg holds the state encodings (IDLE, LAUNCH, WAIT, RESP), the operand width constant 8, and the default TIMEOUT.
- One sub-module, rr_arbiter: inputs req[N_REQ] and ptr[ID_W]; outputs grant_onehot[N_REQ], grant_id[ID_W], any. It is purely combinational.

Test Plan:
- Single request: req_valid=0001, a=0x25, b=0x13, model adder done 9 cycles after add_en -> add_en at cycle 1, rsp_valid with rsp_id=0, rsp_sum=0x38, rsp_err=0.
- Overflow: a=0xF0, b=0x20 from requester 2 -> rsp_sum=0x10, rsp_id=2.
- Round-robin: all four requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0 and req_ready always one-hot.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, no req_ready, no add_en until the handshake.
- Timeout: add_done never asserted -> after 16 WAIT cycles, rsp_err=1 and rsp_sum=0; a late add_done afterwards has no effect. Also cover add_done coinciding with timeout -> rsp_err=0.
- Reset mid-WAIT: rst pulse -> all outputs 0 and rr_ptr=0 immediately; no rsp_valid is ever produced for the aborted job.

Source files
------------

// File: rtl/add_serial_pkg.sv
// Shared definitions for the serial-adder arbiter: FSM encoding, operand width
// and the default abort timeout.
package add_serial_pkg;

  localparam int unsigned OP_W        = 8;
  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Round-robin pointer advance: slot after v, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/add_serial_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter
  import add_serial_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_id,
  output logic             any
);

  logic              found;
  logic [ID_W-1:0]   idx;
  int unsigned       slot;

  assign any = |req;

  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    found        = 1'b0;
    idx          = '0;
    slot         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      slot = (32'(ptr) + k) % N_REQ;
      idx  = ID_W'(slot);
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_id          = idx;
      end
    end
  end

endmodule

// File: rtl/add_serial_arb.sv
// Shares one bit-serial adder among N_REQ requesters: round-robin grant,
// one-cycle launch, bounded wait for done, tagged response with backpressure.
module add_serial_arb
  import add_serial_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [OP_W*N_REQ-1:0] req_a,
  input  logic [OP_W*N_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [OP_W-1:0]       rsp_sum,
  output logic                  rsp_err,
  output logic                  add_en,
  output logic [OP_W-1:0]       add_a,
  output logic [OP_W-1:0]       add_b,
  input  logic [OP_W-1:0]       add_sum,
  input  logic                  add_done,
  output logic                  busy
);

  localparam int unsigned       TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [N_REQ-1:0]   grant_onehot;
  logic [ID_W-1:0]    grant_id;
  logic               any_req;
  logic [TMR_W-1:0]   timer;
  logic               timed_out;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .any          (any_req)
  );

  assign timed_out = (timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (add_done || timed_out) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    add_en    = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    req_ready = grant_onehot;
      LAUNCH:  add_en    = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands, ID and result are registered so they stay stable through WAIT/RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a   <= '0;
      add_b   <= '0;
      rsp_id  <= '0;
      rsp_sum <= '0;
      rsp_err <= 1'b0;
      rr_ptr  <= '0;
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            add_a  <= req_a[grant_id*OP_W +: OP_W];
            add_b  <= req_b[grant_id*OP_W +: OP_W];
            rsp_id <= grant_id;
            rr_ptr <= ID_W'(wrap_inc(32'(grant_id), N_REQ));
          end
        end
        LAUNCH: begin
          timer <= '0;
        end
        WAIT: begin
          // done takes priority over a coincident timeout
          if (add_done) begin
            rsp_sum <= add_sum;
            rsp_err <= 1'b0;
          end else if (timed_out) begin
            rsp_sum <= '0;
            rsp_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
